// File: rtl/tub_pkg.sv
// Shared types and segment constants for the seven-segment value formatter.
package tub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_MINUS = 8'h02;
  localparam logic [7:0] SEG_ZERO  = 8'hFC;

  localparam logic [1:0] MODE_HEX  = 2'b00;
  localparam logic [1:0] MODE_UDEC = 2'b01;
  localparam logic [1:0] MODE_SDEC = 2'b10;

endpackage

// File: rtl/tub_value_formatter_seg_hex_decode.sv
// Nibble to seven-segment code, bit7..bit0 = a,b,c,d,e,f,g,dp, active-high.
module seg_hex_decode (
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  always_comb begin
    case (nib)
      4'h0:    seg = 8'hFC;
      4'h1:    seg = 8'h60;
      4'h2:    seg = 8'hDA;
      4'h3:    seg = 8'hF2;
      4'h4:    seg = 8'h66;
      4'h5:    seg = 8'hB6;
      4'h6:    seg = 8'hBE;
      4'h7:    seg = 8'hE0;
      4'h8:    seg = 8'hFE;
      4'h9:    seg = 8'hF6;
      4'hA:    seg = 8'hEE;
      4'hB:    seg = 8'h3E;
      4'hC:    seg = 8'h9C;
      4'hD:    seg = 8'h7A;
      4'hE:    seg = 8'h9E;
      default: seg = 8'h8E;
    endcase
  end

endmodule

// File: rtl/tub_value_formatter.sv
// Renders a 32-bit value as eight segment codes in hex or (signed) decimal,
// using a bit-serial double-dabble converter for the decimal modes.
module tub_value_formatter
  import tub_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [1:0]  mode,
  input  logic        blank_lz,
  output logic        busy,
  output logic        done,
  output logic [7:0]  tub_1,
  output logic [7:0]  tub_2,
  output logic [7:0]  tub_3,
  output logic [7:0]  tub_4,
  output logic [7:0]  tub_5,
  output logic [7:0]  tub_6,
  output logic [7:0]  tub_7,
  output logic [7:0]  tub_8
);

  state_t             state;
  logic [4:0]         cnt;
  logic [31:0]        val_q;
  logic [39:0]        bcd_q;
  logic [1:0]         mode_q;
  logic               blz_q;
  logic               neg_q;
  logic [7:0]         seg_q    [8];
  logic [7:0]         seg_next [8];
  logic [7:0]         dec_seg  [8];
  logic [3:0]         nib      [8];
  logic [39:0]        bcd_adj;
  logic signed [31:0] wr_s;
  logic               wr_neg;
  logic [31:0]        wr_mag;
  logic               wr_dec;
  logic               is_hex;
  logic               ovf;

  function automatic logic [39:0] bcd_add3(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // 0x80000000 negates to itself, which read unsigned is the correct magnitude.
  assign wr_s    = signed'(wr_data);
  assign wr_dec  = (mode == MODE_UDEC) || (mode == MODE_SDEC);
  assign wr_neg  = (mode == MODE_SDEC) && wr_data[31];
  assign wr_mag  = wr_neg ? unsigned'(-wr_s) : wr_data;
  assign bcd_adj = bcd_add3(bcd_q);
  assign is_hex  = !((mode_q == MODE_UDEC) || (mode_q == MODE_SDEC));
  assign ovf     = !is_hex && ((mode_q == MODE_SDEC) ? (|bcd_q[39:28]) : (|bcd_q[39:32]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= 5'd0;
      for (int k = 0; k < 8; k++) seg_q[k] <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            busy  <= 1'b1;
            cnt   <= 5'd0;
            state <= wr_dec ? ST_CONV : ST_EMIT;
          end
        end
        ST_CONV: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= ST_EMIT;
        end
        ST_EMIT: begin
          for (int k = 0; k < 8; k++) seg_q[k] <= seg_next[k];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && wr_en) begin
      val_q  <= wr_mag;
      bcd_q  <= 40'd0;
      mode_q <= mode;
      blz_q  <= blank_lz;
      neg_q  <= wr_neg;
    end else if (state == ST_CONV) begin
      bcd_q <= {bcd_adj[38:0], val_q[31]};
      val_q <= {val_q[30:0], 1'b0};
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_dig
    assign nib[k] = is_hex ? val_q[31-4*k -: 4] : bcd_q[4*(7-k) +: 4];
    seg_hex_decode u_dec (
      .nib (nib[k]),
      .seg (dec_seg[k])
    );
  end

  always_comb begin
    logic lead;
    lead = 1'b1;
    for (int k = 0; k < 8; k++) begin
      seg_next[k] = dec_seg[k];
      if (!is_hex) begin
        if (mode_q == MODE_SDEC && k == 0) begin
          seg_next[k] = neg_q ? SEG_MINUS : (blz_q ? SEG_BLANK : SEG_ZERO);
        end else begin
          if (nib[k] != 4'd0) lead = 1'b0;
          if (blz_q && lead && k != 7) seg_next[k] = SEG_BLANK;
        end
      end
      if (ovf) seg_next[k] = SEG_MINUS;
    end
  end

  assign tub_1 = seg_q[0] ^ {8{SEG_ACTIVE_LOW}};
  assign tub_2 = seg_q[1] ^ {8{SEG_ACTIVE_LOW}};
  assign tub_3 = seg_q[2] ^ {8{SEG_ACTIVE_LOW}};
  assign tub_4 = seg_q[3] ^ {8{SEG_ACTIVE_LOW}};
  assign tub_5 = seg_q[4] ^ {8{SEG_ACTIVE_LOW}};
  assign tub_6 = seg_q[5] ^ {8{SEG_ACTIVE_LOW}};
  assign tub_7 = seg_q[6] ^ {8{SEG_ACTIVE_LOW}};
  assign tub_8 = seg_q[7] ^ {8{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_tub_value_formatter.sv
// Self-checking bench for tub_value_formatter: vector table, corner sequences, random vs model.
module tb_tub_value_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [1:0]  mode = '0;
  logic        blank_lz = 1'b0;
  logic        busy, done, busy_i, done_i;
  logic [7:0]  t1, t2, t3, t4, t5, t6, t7, t8;
  logic [7:0]  i1, i2, i3, i4, i5, i6, i7, i8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tub_value_formatter #(.SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .mode(mode),
    .blank_lz(blank_lz), .busy(busy), .done(done),
    .tub_1(t1), .tub_2(t2), .tub_3(t3), .tub_4(t4),
    .tub_5(t5), .tub_6(t6), .tub_7(t7), .tub_8(t8)
  );

  tub_value_formatter #(.SEG_ACTIVE_LOW(1'b1)) u_dut_inv (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .mode(mode),
    .blank_lz(blank_lz), .busy(busy_i), .done(done_i),
    .tub_1(i1), .tub_2(i2), .tub_3(i3), .tub_4(i4),
    .tub_5(i5), .tub_6(i6), .tub_7(i7), .tub_8(i8)
  );

  wire [63:0] tubs     = {t1, t2, t3, t4, t5, t6, t7, t8};
  wire [63:0] tubs_inv = {i1, i2, i3, i4, i5, i6, i7, i8};

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    logic        blz;
    logic [63:0] exp;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexseg(input int n);
    logic [7:0] tbl [16];
    tbl = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
            8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    return tbl[n & 15];
  endfunction

  // Reference: integer division for decimal digits, plain nibble shifts for hex.
  function automatic logic [63:0] model(input logic [31:0] d, input logic [1:0] m, input logic blz);
    logic [7:0]  o [8];
    logic [63:0] r;
    longint      mag, p10;
    int          start, dig;
    bit          lead;
    if (m == 2'b01 || m == 2'b10) begin
      mag = longint'({32'h0, d});
      start = 0;
      if (m == 2'b10) begin
        start = 1;
        if (d[31]) mag = 64'sd4294967296 - mag;
      end
      if (mag > ((m == 2'b01) ? 64'sd99999999 : 64'sd9999999)) return {8{8'h02}};
      if (m == 2'b10) o[0] = d[31] ? 8'h02 : (blz ? 8'h00 : 8'hFC);
      lead = 1'b1;
      for (int p = start; p < 8; p++) begin
        p10 = 1;
        for (int e = 0; e < 7 - p; e++) p10 = p10 * 10;
        dig = int'((mag / p10) % 10);
        if (dig != 0) lead = 1'b0;
        o[p] = (blz && lead && p != 7) ? 8'h00 : hexseg(dig);
      end
    end else begin
      for (int p = 0; p < 8; p++) o[p] = hexseg(int'((d >> (28 - 4*p)) & 32'hF));
    end
    r = {o[0], o[1], o[2], o[3], o[4], o[5], o[6], o[7]};
    return r;
  endfunction

  task automatic run_write(input logic [31:0] d, input logic [1:0] m, input logic blz,
                           output int bcyc, output logic done_hi, output logic done_lo,
                           output logic [63:0] got, output logic [63:0] got_inv);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d; mode = m; blank_lz = blz;
    @(posedge clk); #1;
    wr_en = 1'b0;
    bcyc = 0;
    while (busy && bcyc < 100) begin
      @(posedge clk); #1;
      bcyc++;
    end
    done_hi = done;
    got = tubs;
    got_inv = tubs_inv;
    @(posedge clk); #1;
    done_lo = done;
  endtask

  initial begin
    int          bcyc, ndone;
    logic        dh, dl;
    logic [63:0] g, gi, exp;
    logic [31:0] d;
    logic [1:0]  m;
    logic        b;

    vecs[0]  = '{32'h1234ABCD, 2'b00, 1'b0, 64'h60DAF266EE3E9C7A, 1};
    vecs[1]  = '{32'd12345678, 2'b01, 1'b0, 64'h60DAF266B6BEE0FE, 33};
    vecs[2]  = '{32'd0,        2'b01, 1'b1, 64'h00000000000000FC, 33};
    vecs[3]  = '{32'd100000000,2'b01, 1'b0, {8{8'h02}}, 33};
    vecs[4]  = '{32'hFFFFFFD6, 2'b10, 1'b1, 64'h02000000000066DA, 33};
    vecs[5]  = '{32'h80000000, 2'b10, 1'b0, {8{8'h02}}, 33};
    vecs[6]  = '{32'h00000000, 2'b11, 1'b1, {8{8'hFC}}, 1};
    vecs[7]  = '{32'd99999999, 2'b01, 1'b1, {8{8'hF6}}, 33};
    vecs[8]  = '{32'd9999999,  2'b10, 1'b1, {8'h00, {7{8'hF6}}}, 33};
    vecs[9]  = '{32'hFF676981, 2'b10, 1'b1, {8'h02, {7{8'hF6}}}, 33};
    vecs[10] = '{32'd42,       2'b10, 1'b0, 64'hFCFCFCFCFCFC66DA, 33};
    vecs[11] = '{32'd10000000, 2'b10, 1'b0, {8{8'h02}}, 33};

    repeat (3) @(posedge clk);
    #1;
    check("reset_tubs", tubs, 64'h0);
    check("reset_tubs_inv", tubs_inv, {8{8'hFF}});
    check("reset_busy_done", {62'h0, busy, done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_write(vecs[i].data, vecs[i].mode, vecs[i].blz, bcyc, dh, dl, g, gi);
      check($sformatf("vec%0d_tubs", i), g, vecs[i].exp);
      check($sformatf("vec%0d_tubs_inv", i), gi, ~vecs[i].exp);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcyc), 64'(vecs[i].busy_cyc));
      check($sformatf("vec%0d_done_pulse", i), {62'h0, dh, dl}, 64'h2);
    end

    // Second write while busy is dropped; only one done pulse for the first.
    ndone = 0;
    for (int cyc = 0; cyc < 46; cyc++) begin
      @(negedge clk);
      wr_en = (cyc == 0 || cyc == 10);
      wr_data = (cyc == 0) ? 32'd5 : 32'd7;
      mode = 2'b01; blank_lz = 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    wr_en = 1'b0;
    check("busy_drop_tub8", 64'(t8), 64'hB6);
    check("busy_drop_done_count", 64'(ndone), 64'd1);

    // A write in the done cycle is accepted.
    run_write(32'hCAFEF00D, 2'b00, 1'b0, bcyc, dh, dl, g, gi);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 32'hDEADBEEF; mode = 2'b00;
    @(posedge clk); #1;
    wr_en = 1'b0;
    while (!done && bcyc < 100) begin
      @(posedge clk); #1;
      bcyc++;
    end
    @(negedge clk);
    wr_en = 1'b1; wr_data = 32'h00000009; mode = 2'b00;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("done_cycle_accept_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("done_cycle_accept_tubs", tubs, model(32'h9, 2'b00, 1'b0));

    // Reset in the middle of a decimal conversion.
    run_write(32'd31415926, 2'b01, 1'b0, bcyc, dh, dl, g, gi);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 32'd12345678; mode = 2'b01;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_busy_done", {62'h0, busy, done}, 64'h0);
    check("midreset_tubs", tubs, 64'h0);
    check("midreset_tubs_inv", tubs_inv, {8{8'hFF}});
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midreset_no_done", 64'(ndone), 64'd0);
    check("midreset_tubs_hold", tubs, 64'h0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'd99999990 + $urandom_range(0, 20);
        2:       d = 32'd0 - $urandom_range(0, 10000010);
        default: d = $urandom_range(0, 2000);
      endcase
      m = 2'($urandom_range(0, 3));
      b = 1'($urandom_range(0, 1));
      exp = model(d, m, b);
      run_write(d, m, b, bcyc, dh, dl, g, gi);
      check($sformatf("rand%0d_tubs d=%h m=%0d b=%0d", n, d, m, b), g, exp);
      check($sformatf("rand%0d_busy_cycles", n), 64'(bcyc),
            (m == 2'b01 || m == 2'b10) ? 64'd33 : 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
